// File: rtl/hilo_sequencer_if.sv
// Issue/unit handshake bundle between the decode stage, hilo_sequencer and the
// MULTU/HiLo datapath. The sequencer takes the slave side, the issuer the master side.
interface hilo_sequencer_if #(
    parameter int CNT_W = 6
);
    logic             issue_valid;
    logic [5:0]       funct;
    logic             abort;
    logic             issue_ready;
    logic             unit_load;
    logic             unit_step;
    logic             unit_mode;
    logic             hilo_we;
    logic [1:0]       sel_hilo;
    logic             stall;
    logic             busy;
    logic [CNT_W-1:0] step_cnt;

    modport master (
        output issue_valid, funct, abort,
        input  issue_ready, unit_load, unit_step, unit_mode, hilo_we,
               sel_hilo, stall, busy, step_cnt
    );

    modport slave (
        input  issue_valid, funct, abort,
        output issue_ready, unit_load, unit_step, unit_mode, hilo_we,
               sel_hilo, stall, busy, step_cnt
    );
endinterface

// File: rtl/hilo_sequencer.sv
// Issue-side FSM for the iterative MULTU unit and Hi/Lo pair: load, STEPS iterations, write-back.
// Optional DIVU support is enabled by defining HILO_SEQ_DIVU_EN.
module hilo_sequencer #(
    parameter int STEPS = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    hilo_sequencer_if.slave    bus
);
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        WB
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_stepCnt;
    logic [CNT_W-1:0] w_stepCntNext;
    logic [CNT_W-1:0] w_lastIdx;
    logic             w_isMul;
    logic             w_isDiv;
    logic             w_isRead;
    logic             w_interlocked;
    logic             w_start;

    assign w_isMul = (bus.funct == FUNCT_MULTU);
    assign w_isRead = (bus.funct == FUNCT_MFHI) || (bus.funct == FUNCT_MFLO);

`ifdef HILO_SEQ_DIVU_EN
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

    logic r_unitMode;

    assign w_isDiv = (bus.funct == FUNCT_DIVU);
    // DIVU runs one extra iteration for the remainder-restore step.
    assign w_lastIdx = r_unitMode ? CNT_W'(STEPS) : CNT_W'(STEPS - 1);
    assign bus.unit_mode = r_unitMode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_unitMode <= 1'b0;
        end else if (w_start) begin
            r_unitMode <= w_isDiv;
        end
    end
`else
    assign w_isDiv = 1'b0;
    assign w_lastIdx = CNT_W'(STEPS - 1);
    assign bus.unit_mode = 1'b0;
`endif

    assign w_start = (r_state == IDLE) && bus.issue_valid && (w_isMul || w_isDiv) && !bus.abort;
    assign w_interlocked = bus.issue_valid && (w_isMul || w_isDiv || w_isRead);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_stepCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_stepCnt <= w_stepCntNext;
        end
    end

    // Stall is raised through WB too, since Hi/Lo only update at the end of that cycle.
    always_comb begin
        w_stateNext     = r_state;
        w_stepCntNext   = r_stepCnt;
        bus.issue_ready = 1'b0;
        bus.unit_load   = 1'b0;
        bus.unit_step   = 1'b0;
        bus.hilo_we     = 1'b0;
        bus.sel_hilo    = 2'b00;
        bus.stall       = 1'b0;
        bus.busy        = (r_state != IDLE);
        bus.step_cnt    = r_stepCnt;

        case (r_state)
            IDLE: begin
                bus.issue_ready = 1'b1;
                if (bus.issue_valid && bus.funct == FUNCT_MFHI) begin
                    bus.sel_hilo = 2'b01;
                end else if (bus.issue_valid && bus.funct == FUNCT_MFLO) begin
                    bus.sel_hilo = 2'b10;
                end
                if (w_start) begin
                    w_stateNext = LOAD;
                end
            end
            LOAD: begin
                bus.unit_load = 1'b1;
                bus.stall     = w_interlocked;
                w_stepCntNext = '0;
                w_stateNext   = bus.abort ? IDLE : RUN;
            end
            RUN: begin
                bus.unit_step = 1'b1;
                bus.stall     = w_interlocked;
                if (bus.abort) begin
                    w_stateNext   = IDLE;
                    w_stepCntNext = '0;
                end else if (r_stepCnt == w_lastIdx) begin
                    w_stateNext   = WB;
                    w_stepCntNext = '0;
                end else begin
                    w_stepCntNext = r_stepCnt + CNT_W'(1);
                end
            end
            WB: begin
                bus.hilo_we = 1'b1;
                bus.stall   = w_interlocked;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext   = IDLE;
                w_stepCntNext = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_hilo_sequencer.sv
// Self-checking bench for hilo_sequencer: directed latency/interlock/abort/reset scenarios
// followed by randomized issue traffic, all checked against a schedule-based reference model.
module tb_hilo_sequencer;
    localparam int STEPS = 32;
    localparam int CNT_W = 6;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic clk;
    logic rst_n;

    hilo_sequencer_if #(.CNT_W(CNT_W)) bus ();

    hilo_sequencer #(.STEPS(STEPS), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    bit checkEn = 0;

    // Reference model: an accepted operation is a start cycle plus a length.
    int opStart = -1;
    int opLen = STEPS;
    bit modelMode = 0;

    int weQ[$];
    int loadCyc = -1;
    int stepCount = 0;
    int stallCount = 0;
    int lastSelLo = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit isStartFunct(input logic [5:0] f);
`ifdef HILO_SEQ_DIVU_EN
        return (f == F_MULTU) || (f == F_DIVU);
`else
        return (f == F_MULTU);
`endif
    endfunction

    function automatic bit isSeqFunct(input logic [5:0] f);
        return isStartFunct(f) || (f == F_MFHI) || (f == F_MFLO);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d actual %0d expected %0d", name, cycle, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [5:0] f, input logic a);
        bus.issue_valid = v;
        bus.funct = f;
        bus.abort = a;
        @(posedge clk);
        #1;
    endtask

    // Model update uses the inputs that were present during the cycle just ending.
    always @(posedge clk) begin
        if (!rst_n) begin
            opStart = -1;
            modelMode = 0;
        end else if (opStart >= 0) begin
            if (bus.abort && cycle <= opStart + 1 + opLen) begin
                opStart = -1;
            end else if (cycle == opStart + 2 + opLen) begin
                opStart = -1;
            end
        end else if (bus.issue_valid && isStartFunct(bus.funct) && !bus.abort) begin
            opStart = cycle;
            opLen = (bus.funct == F_DIVU) ? STEPS + 1 : STEPS;
            modelMode = (bus.funct == F_DIVU);
        end
        cycle = cycle + 1;
    end

    always @(negedge clk) begin
        bit active;
        bit expStep;
        int expCnt;
        int expSel;
        if (checkEn) begin
            active = (opStart >= 0);
            expStep = active && (cycle >= opStart + 2) && (cycle <= opStart + 1 + opLen);
            expCnt = expStep ? cycle - opStart - 2 : 0;
            expSel = 0;
            if (!active && bus.issue_valid && bus.funct == F_MFHI) expSel = 1;
            if (!active && bus.issue_valid && bus.funct == F_MFLO) expSel = 2;
            checkOutput("busy", bus.busy, active);
            checkOutput("issue_ready", bus.issue_ready, !active);
            checkOutput("unit_load", bus.unit_load, active && cycle == opStart + 1);
            checkOutput("unit_step", bus.unit_step, expStep);
            checkOutput("hilo_we", bus.hilo_we, active && cycle == opStart + 2 + opLen);
            checkOutput("step_cnt", bus.step_cnt, expCnt);
            checkOutput("sel_hilo", bus.sel_hilo, expSel);
            checkOutput("stall", bus.stall, active && bus.issue_valid && isSeqFunct(bus.funct));
            checkOutput("unit_mode", bus.unit_mode, modelMode);

            if (bus.hilo_we) weQ.push_back(cycle);
            if (bus.unit_load) loadCyc = cycle;
            if (bus.unit_step) stepCount++;
            if (bus.stall) stallCount++;
            if (bus.sel_hilo == 2'b10 && !bus.stall) lastSelLo = cycle;
        end
    end

    task automatic runOp(input logic [5:0] f, input int expSteps, input string tag);
        int acc;
        int n0;
        int done;
        n0 = weQ.size();
        stepCount = 0;
        loadCyc = -1;
        acc = cycle;
        applyStimulus(1'b1, f, 1'b0);
        done = 0;
        for (int i = 0; i < 100 && done == 0; i++) begin
            if (weQ.size() > n0) done = 1;
            else applyStimulus(1'b0, 6'd0, 1'b0);
        end
        checkOutput({tag, " timeout"}, done, 1);
        if (done == 1) begin
            checkOutput({tag, " load offset"}, loadCyc - acc, 1);
            checkOutput({tag, " step cycles"}, stepCount, expSteps);
            checkOutput({tag, " we offset"}, weQ[n0] - acc, expSteps + 2);
            checkOutput({tag, " busy after"}, bus.busy, 0);
        end
    endtask

    initial begin
        int acc;
        int n0;
        logic [5:0] f;
        logic v;
        logic a;

        rst_n = 1'b0;
        bus.issue_valid = 1'b0;
        bus.funct = 6'd0;
        bus.abort = 1'b0;
        @(posedge clk);
        #1;
        checkEn = 1;
        applyStimulus(1'b0, 6'd0, 1'b0);
        applyStimulus(1'b0, 6'd0, 1'b0);
        rst_n = 1'b1;
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset issue_ready", bus.issue_ready, 1);
        checkOutput("reset step_cnt", bus.step_cnt, 0);
        checkOutput("reset unit_mode", bus.unit_mode, 0);
        applyStimulus(1'b0, 6'd0, 1'b0);

        $display("[TB] basic MULTU latency");
        runOp(F_MULTU, 32, "multu");

        $display("[TB] MFLO held during MULTU");
        stallCount = 0;
        lastSelLo = -1;
        acc = cycle;
        applyStimulus(1'b1, F_MULTU, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 80 && lastSelLo < 0; i++) applyStimulus(1'b1, F_MFLO, 1'b0);
        applyStimulus(1'b0, 6'd0, 1'b0);
        checkOutput("mflo release offset", lastSelLo - acc, 35);
        checkOutput("mflo stall cycles", stallCount, 30);

        $display("[TB] abort in 10th RUN cycle");
        n0 = weQ.size();
        applyStimulus(1'b1, F_MULTU, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 6'd0, 1'b0);
        checkOutput("abort pre step_cnt", bus.step_cnt, 9);
        applyStimulus(1'b0, 6'd0, 1'b1);
        checkOutput("abort busy", bus.busy, 0);
        checkOutput("abort step_cnt", bus.step_cnt, 0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 6'd0, 1'b0);
        checkOutput("abort no we", weQ.size(), n0);

        $display("[TB] reset at step_cnt 20");
        n0 = weQ.size();
        applyStimulus(1'b1, F_MULTU, 1'b0);
        for (int i = 0; i < 21; i++) applyStimulus(1'b0, 6'd0, 1'b0);
        checkOutput("prereset step_cnt", bus.step_cnt, 20);
        rst_n = 1'b0;
        applyStimulus(1'b0, 6'd0, 1'b0);
        rst_n = 1'b1;
        checkOutput("midreset busy", bus.busy, 0);
        checkOutput("midreset step_cnt", bus.step_cnt, 0);
        checkOutput("midreset unit_step", bus.unit_step, 0);
        checkOutput("midreset issue_ready", bus.issue_ready, 1);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 6'd0, 1'b0);
        checkOutput("midreset no we", weQ.size(), n0);
        runOp(F_MULTU, 32, "postreset");

        $display("[TB] MULTU issued in WB cycle");
        n0 = weQ.size();
        applyStimulus(1'b1, F_MULTU, 1'b0);
        for (int i = 0; i < 33; i++) applyStimulus(1'b0, 6'd0, 1'b0);
        stallCount = 0;
        checkOutput("wb cycle we", bus.hilo_we, 1);
        applyStimulus(1'b1, F_MULTU, 1'b0);
        applyStimulus(1'b1, F_MULTU, 1'b0);
        for (int i = 0; i < 60 && weQ.size() < n0 + 2; i++) applyStimulus(1'b0, 6'd0, 1'b0);
        checkOutput("b2b stall cycles", stallCount, 1);
        checkOutput("b2b we count", weQ.size() - n0, 2);
        if (weQ.size() >= n0 + 2) checkOutput("b2b we spacing", weQ[n0 + 1] - weQ[n0], 35);

        $display("[TB] DIVU");
`ifdef HILO_SEQ_DIVU_EN
        runOp(F_DIVU, 33, "divu");
        checkOutput("divu mode held", bus.unit_mode, 1);
`else
        applyStimulus(1'b1, F_DIVU, 1'b0);
        checkOutput("divu ignored busy", bus.busy, 0);
        checkOutput("divu ignored ready", bus.issue_ready, 1);
        checkOutput("divu ignored mode", bus.unit_mode, 0);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0, 1: f = F_MULTU;
                2: f = F_MFHI;
                3: f = F_MFLO;
                4: f = F_DIVU;
                default: f = 6'($urandom_range(0, 63));
            endcase
            v = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            applyStimulus(v, f, a);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 6'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
